ma_stage: RTL

MA_STAGE -- requirements
Module: ma_stage

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/ma_rw_latch.sv | 83 ++++++++
 rtl/ma_stage.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared pipeline definitions: datapath widths, control-bus bit positions
// and the memory-access stage state encoding.
// Ports: none (package).
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 22;

  // Control-bus bit positions
  localparam int IS_ST   = 0;
  localparam int IS_LD   = 1;
  localparam int IS_WB   = 6;
  localparam int IS_CALL = 8;

  typedef enum logic {
    MA_IDLE   = 1'b0,
    MA_ACCESS = 1'b1
  } ma_state_e;

  // Word accesses only: the two low address bits must be zero.
  function automatic logic word_aligned(input logic [1:0] addr_lo);
    return (addr_lo == 2'b00);
  endfunction

endpackage

// File: rtl/ma_rw_latch.sv
// ---------------------------------------------------------------------------
// ma_rw_latch
// MA/RW pipeline register. When en is high every field is loaded from the
// inputs. When en is low the data fields hold and valid drops, so the RW
// stage sees a bubble. clr is a synchronous clear of all fields.
// Ports:
//   clk            clock, rising edge
//   clr            synchronous clear (high = clear)
//   en             load enable
//   *_i            PC, load result, ALU result, IR, control bus, valid in
//   *_o            registered copies of the above
// ---------------------------------------------------------------------------
module ma_rw_latch
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   ld_result_i,
  input  logic [XLEN-1:0]   alu_result_i,
  input  logic [XLEN-1:0]   ir_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              valid_i,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   ld_result_o,
  output logic [XLEN-1:0]   alu_result_o,
  output logic [XLEN-1:0]   ir_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              valid_o
);

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   ld_result_q, ld_result_d;
  logic [XLEN-1:0]   alu_result_q, alu_result_d;
  logic [XLEN-1:0]   ir_q, ir_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              valid_q, valid_d;

  // Data holds when not enabled; valid defaults low so a held slot is a bubble.
  always_comb begin
    pc_d         = pc_q;
    ld_result_d  = ld_result_q;
    alu_result_d = alu_result_q;
    ir_d         = ir_q;
    ctrl_d       = ctrl_q;
    valid_d      = 1'b0;
    if (en) begin
      pc_d         = pc_i;
      ld_result_d  = ld_result_i;
      alu_result_d = alu_result_i;
      ir_d         = ir_i;
      ctrl_d       = ctrl_i;
      valid_d      = valid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pc_q         <= '0;
      ld_result_q  <= '0;
      alu_result_q <= '0;
      ir_q         <= '0;
      ctrl_q       <= '0;
      valid_q      <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ld_result_q  <= ld_result_d;
      alu_result_q <= alu_result_d;
      ir_q         <= ir_d;
      ctrl_q       <= ctrl_d;
      valid_q      <= valid_d;
    end
  end

  assign pc_o         = pc_q;
  assign ld_result_o  = ld_result_q;
  assign alu_result_o = alu_result_q;
  assign ir_o         = ir_q;
  assign ctrl_o       = ctrl_q;
  assign valid_o      = valid_q;

endmodule

// File: rtl/ma_stage.sv
// ---------------------------------------------------------------------------
// ma_stage
// Memory-access pipeline stage. Loads and stores issue one registered
// request to data memory and stall upstream until dmem_ready or until the
// wait counter expires. Non-memory instructions pass to the MA/RW latch in
// one cycle. Misaligned accesses and timeouts set the sticky mem_err flag
// and still deliver the instruction with a zero load result.
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   input_MA_*                   EX/MA latch contents (PC, ALU result,
//                                store data, IR, control bus, valid)
//   MA_stall                     upstream must hold input_MA_* while high
//   dmem_req/we/addr/wdata       registered data-memory request
//   dmem_rdata, dmem_ready       memory read data and completion
//   output_RW_*                  MA/RW latch contents
//   mem_err                      sticky misalignment / timeout flag
// Parameter TIMEOUT: maximum ACCESS cycles spent waiting for dmem_ready.
// ---------------------------------------------------------------------------
module ma_stage
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   input_MA_PC,
  input  logic [XLEN-1:0]   input_MA_ALU_Result,
  input  logic [XLEN-1:0]   input_MA_op2,
  input  logic [XLEN-1:0]   input_MA_IR,
  input  logic [CTRL_W-1:0] input_MA_controlBus,
  input  logic              input_MA_valid,
  output logic              MA_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_ready,
  output logic [XLEN-1:0]   output_RW_PC,
  output logic [XLEN-1:0]   output_RW_Ld_Result,
  output logic [XLEN-1:0]   output_RW_ALU_Result,
  output logic [XLEN-1:0]   output_RW_IR,
  output logic [CTRL_W-1:0] output_RW_controlBus,
  output logic              output_RW_valid,
  output logic              mem_err
);

  localparam int              CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  ma_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dmem_req_q, dmem_req_d;
  logic             dmem_we_q, dmem_we_d;
  logic [XLEN-1:0]  dmem_addr_q, dmem_addr_d;
  logic [XLEN-1:0]  dmem_wdata_q, dmem_wdata_d;
  logic             mem_err_q, mem_err_d;

  logic             is_st, is_ld_only, memop, aligned;
  logic             stall_raw;
  logic             rw_load;
  logic [XLEN-1:0]  rw_ld_result;
  logic             rw_clr;

  // A word with both isLd and isSt set behaves as a store.
  assign is_st      = input_MA_controlBus[IS_ST];
  assign is_ld_only = input_MA_controlBus[IS_LD] & ~is_st;
  assign memop      = input_MA_valid & (input_MA_controlBus[IS_LD] | is_st);
  assign aligned    = word_aligned(input_MA_ALU_Result[1:0]);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    mem_err_d    = mem_err_q;
    stall_raw    = 1'b0;
    rw_load      = 1'b0;
    rw_ld_result = '0;

    unique case (state_q)
      MA_IDLE: begin
        // dmem_ready is never looked at here, so stray pulses are ignored.
        if (memop && aligned) begin
          stall_raw    = 1'b1;
          state_d      = MA_ACCESS;
          cnt_d        = '0;
          dmem_req_d   = 1'b1;
          dmem_we_d    = is_st;
          dmem_addr_d  = input_MA_ALU_Result;
          dmem_wdata_d = input_MA_op2;
        end else if (memop) begin
          mem_err_d = 1'b1;
          rw_load   = 1'b1;
        end else if (input_MA_valid) begin
          rw_load = 1'b1;
        end
      end

      MA_ACCESS: begin
        if (dmem_ready) begin
          rw_load      = 1'b1;
          rw_ld_result = is_ld_only ? dmem_rdata : '0;
          dmem_req_d   = 1'b0;
          dmem_we_d    = 1'b0;
          state_d      = MA_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Give up: deliver the instruction without data and release upstream.
          rw_load    = 1'b1;
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          mem_err_d  = 1'b1;
          state_d    = MA_IDLE;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          stall_raw = 1'b1;
        end
      end

      default: state_d = MA_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= MA_IDLE;
      cnt_q        <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      mem_err_q    <= mem_err_d;
    end
  end

  assign rw_clr = ~rst_n;

  ma_rw_latch u_rw_latch (
    .clk          (clk),
    .clr          (rw_clr),
    .en           (rw_load),
    .pc_i         (input_MA_PC),
    .ld_result_i  (rw_ld_result),
    .alu_result_i (input_MA_ALU_Result),
    .ir_i         (input_MA_IR),
    .ctrl_i       (input_MA_controlBus),
    .valid_i      (input_MA_valid),
    .pc_o         (output_RW_PC),
    .ld_result_o  (output_RW_Ld_Result),
    .alu_result_o (output_RW_ALU_Result),
    .ir_o         (output_RW_IR),
    .ctrl_o       (output_RW_controlBus),
    .valid_o      (output_RW_valid)
  );

  // Stall is forced low while reset is asserted even if a memop is presented.
  assign MA_stall   = rst_n & stall_raw;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign mem_err    = mem_err_q;

endmodule
